alu_ex_mem_stage: RTL and testbench
===================================

Name: alu_ex_mem_stage

Overview:
Execute-to-memory pipeline stage that sits directly downstream of the combinational ALU.
- Captures the ALU result, the four ALU flags, the opcode and the destination register behind a valid/ready handshake.
- Buffers up to two entries (main + skid) so back-to-back issue runs with zero bubbles.
- Maintains the architectural status-flag register, a forwarding tap for the youngest in-flight result, and a retired-op counter.

Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, destination register index width
- CNT_W, 16, retired-op counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream has an ALU op
- in_ready  out  1  stage can accept
- in_result  in  DATA_W  ALU result
- in_flags  in  4  {negative, zero, carry, overflow} from ALU
- in_opcode  in  4  ALU opcode
- in_rd  in  REG_W  destination register
- in_set_flags  in  1  op updates status register
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts
- out_result  out  DATA_W  head result
- out_flags  out  4  head flags
- out_opcode  out  4  head opcode
- out_rd  out  REG_W  head destination
- out_illegal  out  1  head opcode > 4'b0110
- status_flags  out  4  architectural {N,Z,C,V}
- fwd_valid  out  1  forwarding tap valid
- fwd_rd  out  REG_W  youngest in-flight destination
- fwd_result  out  DATA_W  youngest in-flight result
- retired_count  out  CNT_W  count of output handshakes

Behaviour:
- One clock, clk. Reset rst_n is synchronous, active-low. Every output is registered or derived from registers.
- Reset values: both entries invalid; out_valid=0; all payload outputs 0; status_flags=4'b0000; retired_count=0; fwd_valid=0; in_ready=1 in the cycle after reset.
- Accept occurs when in_valid && in_ready. Retire occurs when out_valid && out_ready.
- in_ready = !skid_valid (registered). It never depends combinationally on out_ready.
- Latency: an op accepted in cycle N appears at out_* in cycle N+1 when main is empty or retiring in cycle N.
- Throughput: one op per cycle while out_ready=1.
- Storage transitions:
  - Main empty or retiring, skid empty: the accept loads main.
  - Main full and not retiring: the accept loads skid; in_ready drops next cycle.
  - Retire with skid full: skid moves to main, skid is cleared, and a same-cycle accept is impossible (in_ready=0).
- Ordering is strict FIFO; main is always the head.
- out_illegal=1 for opcodes 4'b0111–4'b1111. Illegal payloads pass through unchanged.
- Status register update:
  - Written at accept time (program order) when in_set_flags=1 and the opcode is legal.
  - Loaded with in_flags verbatim. Flags from logical/shift ops are taken as supplied.
  - Illegal ops and ops with in_set_flags=0 leave it unchanged.
- Forwarding tap:
  - fwd_rd/fwd_result come from skid if skid is valid, else from main.
  - fwd_valid = (that entry valid) && (rd != 0).
- retired_count increments by 1 on each retire and wraps from 2^CNT_W-1 to 0.
- flush:
  - Clears both entries next cycle.
  - Has priority over a same-cycle accept: the accepted op is dropped and status_flags is not updated by it.
  - status_flags updates from earlier accepts are kept.
  - retired_count still counts a same-cycle retire.
- Reset has priority over flush and all other activity, including mid-stall.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD=4'b0000 … OP_SRL=4'b0110 and OP_LAST_LEGAL;
  - typedef alu_flags_t as a packed struct {negative, zero, carry, overflow};
  - typedef ex_entry_t as a packed struct {result, flags, opcode, rd};
  - function is_legal_op.
- One sub-module is natural: skid_buffer, a 2-entry valid/ready buffer over ex_entry_t.
- Status register, forwarding mux and counter stay in the top.

Test Plan:
- Reset with rst_n=0 for 2 cycles → out_valid=0, status_flags=0, retired_count=0, in_ready=1.
- Stream ADD result 32'h0000_0005 rd=3, then SUB result 0 rd=4 set_flags=1 flags=4'b0100, out_ready=1 → outputs appear 1 cycle after each accept with no bubble; status_flags=4'b0100; retired_count=2.
- Hold out_ready=0 and offer 3 ops → first two accepted (main, skid), in_ready=0 from the cycle after the second; fwd_rd equals the second op's rd. Raise out_ready → FIFO order preserved and the third op is accepted once skid drains.
- Opcode 4'b1001 with set_flags=1, flags=4'b1111 → out_illegal=1, status_flags unchanged.
- Assert flush with in_valid=1 and two entries full → next cycle out_valid=0, fwd_valid=0, dropped op never appears; an op with rd=0 → fwd_valid=0.
- Preload retired_count to 16'hFFFF via 65535 retires (or force) then one retire → retired_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute-to-memory stage.
package alu_pkg;

  // Widths of the payload carried through the stage.
  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_W  = 5;

  // ALU opcodes. Anything above OP_LAST_LEGAL is treated as illegal.
  localparam logic [3:0] OP_ADD        = 4'b0000;
  localparam logic [3:0] OP_SUB        = 4'b0001;
  localparam logic [3:0] OP_AND        = 4'b0010;
  localparam logic [3:0] OP_OR         = 4'b0011;
  localparam logic [3:0] OP_XOR        = 4'b0100;
  localparam logic [3:0] OP_SLL        = 4'b0101;
  localparam logic [3:0] OP_SRL        = 4'b0110;
  localparam logic [3:0] OP_LAST_LEGAL = OP_SRL;

  // Status flags in {N,Z,C,V} order, matching the ALU flag bus.
  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

  // One in-flight operation held by the stage.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    alu_flags_t            flags;
    logic [3:0]            opcode;
    logic [ALU_REG_W-1:0]  rd;
  } ex_entry_t;

  // An opcode is legal when it is one of the defined ALU operations.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_ex_mem_stage_skid_buffer.sv
// Two-entry valid/ready buffer (main + skid) over ex_entry_t.
// Main is always the FIFO head; skid only fills when main is stalled,
// and in_ready is a pure register output so it never depends on out_ready.
module alu_ex_mem_stage_skid_buffer
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n_i,
  input  logic      flush_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  ex_entry_t in_entry_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output ex_entry_t out_entry_o,
  output logic      skid_valid_o,
  output ex_entry_t skid_entry_o
);

  logic      main_vld_q, main_vld_d;
  logic      skid_vld_q, skid_vld_d;
  ex_entry_t main_q, main_d;
  ex_entry_t skid_q, skid_d;
  logic      accept;
  logic      retire;

  assign in_ready_o   = ~skid_vld_q;
  assign accept       = in_valid_i & ~skid_vld_q;
  assign retire       = main_vld_q & out_ready_i;

  assign out_valid_o  = main_vld_q;
  assign out_entry_o  = main_q;
  assign skid_valid_o = skid_vld_q;
  assign skid_entry_o = skid_q;

  // Next-state for both entries; flush overrides any accept or move.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Skid full: no accept is possible; on retire the skid entry
      // becomes the new head and main stays valid.
      if (retire) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!main_vld_q || retire) begin
      // Main is free this cycle: an accept goes straight to the head.
      main_vld_d = accept;
      if (accept) begin
        main_d = in_entry_i;
      end
    end else if (accept) begin
      // Main is stalled: park the new op in skid.
      skid_vld_d = 1'b1;
      skid_d     = in_entry_i;
    end
  end

  // Entry registers; reset clears valids and payloads.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/alu_ex_mem_stage.sv
// Execute-to-memory stage behind the combinational ALU: buffers up to two
// ops, keeps the architectural status flags, exposes a forwarding tap for
// the youngest in-flight result and counts retired ops.
// DATA_W and REG_W must match the payload widths in alu_pkg.
module alu_ex_mem_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_W  = ALU_REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic [3:0]        in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [3:0]        out_opcode,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_illegal,
  output logic [3:0]        status_flags,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_result,
  output logic [CNT_W-1:0]  retired_count
);

  ex_entry_t  in_entry;
  ex_entry_t  head_entry;
  ex_entry_t  skid_entry;
  ex_entry_t  fwd_entry;
  logic       head_valid;
  logic       skid_valid;
  logic       accept;
  logic       retire;
  logic       status_we;

  alu_flags_t       status_q, status_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  assign in_entry.result = in_result;
  assign in_entry.flags  = alu_flags_t'(in_flags);
  assign in_entry.opcode = in_opcode;
  assign in_entry.rd     = in_rd;

  alu_ex_mem_stage_skid_buffer u_skid (
    .clk          (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_entry_i   (in_entry),
    .out_valid_o  (head_valid),
    .out_ready_i  (out_ready),
    .out_entry_o  (head_entry),
    .skid_valid_o (skid_valid),
    .skid_entry_o (skid_entry)
  );

  assign accept = in_valid & in_ready;
  assign retire = head_valid & out_ready;

  // Head entry drives the downstream interface directly from registers.
  assign out_valid   = head_valid;
  assign out_result  = head_entry.result;
  assign out_flags   = head_entry.flags;
  assign out_opcode  = head_entry.opcode;
  assign out_rd      = head_entry.rd;
  assign out_illegal = ~is_legal_op(head_entry.opcode);

  // Forwarding tap: skid holds the youngest op whenever it is valid.
  always_comb begin
    fwd_entry = skid_valid ? skid_entry : head_entry;
    fwd_valid = (skid_valid | head_valid) & (fwd_entry.rd != '0);
    fwd_rd    = fwd_entry.rd;
    fwd_result = fwd_entry.result;
  end

  // Status flags follow program order, so they are written at accept;
  // a flushed accept never reaches the architectural state.
  always_comb begin
    status_we = accept & ~flush & in_set_flags & is_legal_op(in_opcode);
    status_d  = status_we ? alu_flags_t'(in_flags) : status_q;
  end

  // Retire counter wraps naturally; a retire in a flush cycle still counts.
  always_comb begin
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  // Architectural status and retire counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q  <= '0;
      retired_q <= '0;
    end else begin
      status_q  <= status_d;
      retired_q <= retired_d;
    end
  end

  assign status_flags  = status_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_alu_ex_mem_stage.sv
// Scoreboard bench for alu_ex_mem_stage: the driver pushes each accepted op,
// a monitor pops and compares on every output handshake.
module tb_alu_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags, in_opcode;
  logic [4:0]  in_rd;
  logic        in_set_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags, out_opcode;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [3:0]  status_flags;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_result;
  logic [15:0] retired_count;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ret_model = 0;
  logic [3:0] st_model = 4'h0;

  alu_ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_illegal(out_illegal),
    .status_flags(status_flags),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op (called just after a rising edge) and hold it until accepted.
  task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [4:0] rd,
                       input logic [3:0] fl, input logic sf, input logic ill);
    int waited = 0;
    in_valid = 1'b1; in_opcode = op; in_result = res; in_rd = rd;
    in_flags = fl; in_set_flags = sf;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
    end else begin
      sb.push_back('{res, fl, op, rd, ill});
      if (sf && !ill) st_model = fl;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Let every expected op retire, bounded.
  task automatic drain();
    int w = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d ops still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare the head against the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: rd %h result %h, required no output", out_rd, out_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_flags", 32'(out_flags), 32'(e.fl));
          chk("out_opcode", 32'(out_opcode), 32'(e.op));
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
        ret_model++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_flags = '0; in_opcode = '0; in_rd = '0; in_set_flags = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_status", 32'(status_flags), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream, no bubble
    out_ready = 1'b1;
    issue(4'b0000, 32'h0000_0005, 5'd3, 4'b0000, 1'b0, 1'b0);
    chk("lat_valid1", 32'(out_valid), 32'd1);
    chk("lat_rd1", 32'(out_rd), 32'd3);
    issue(4'b0001, 32'h0000_0000, 5'd4, 4'b0100, 1'b1, 1'b0);
    chk("lat_valid2", 32'(out_valid), 32'd1);
    chk("lat_rd2", 32'(out_rd), 32'd4);
    chk("status_sub", 32'(status_flags), 32'h4);
    drain();
    chk("retired_two", 32'(retired_count), 32'd2);
    chk("empty_after_drain", 32'(out_valid), 32'd0);

    // Stall: fill main and skid, third op waits
    out_ready = 1'b0;
    issue(4'b0010, 32'h0000_00A7, 5'd7, 4'b0000, 1'b0, 1'b0);
    issue(4'b0011, 32'h0000_00B9, 5'd9, 4'b0000, 1'b0, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("stall_fwd_rd", 32'(fwd_rd), 32'd9);
    chk("stall_fwd_result", fwd_result, 32'h0000_00B9);
    chk("stall_head_rd", 32'(out_rd), 32'd7);
    fork
      issue(4'b0100, 32'h0000_00C2, 5'd2, 4'b0000, 1'b0, 1'b0);
      begin
        @(posedge clk); #1;
        chk("stall_hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal opcode and flag-write rules
    issue(4'b1001, 32'hDEAD_BEEF, 5'd12, 4'b1111, 1'b1, 1'b1);
    chk("illegal_status", 32'(status_flags), 32'h4);
    issue(4'b0010, 32'h0000_000F, 5'd13, 4'b0010, 1'b0, 1'b0);
    chk("noset_status", 32'(status_flags), 32'h4);
    issue(4'b0110, 32'h0000_0001, 5'd14, 4'b0010, 1'b1, 1'b0);
    chk("srl_status", 32'(status_flags), 32'h2);
    chk("status_model", 32'(status_flags), 32'(st_model));
    drain();

    // Flush with both entries full and in_valid high
    out_ready = 1'b0;
    issue(4'b0011, 32'h0000_0011, 5'd5, 4'b0000, 1'b0, 1'b0);
    issue(4'b0100, 32'h0000_0022, 5'd6, 4'b0000, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_opcode = 4'b0000; in_result = 32'h33;
    in_rd = 5'd8; in_flags = 4'b1001; in_set_flags = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_status", 32'(status_flags), 32'h2);
    // Flush beats a same-cycle accept into an empty stage
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", 32'(out_valid), 32'd0);
    chk("flush_drop_status", 32'(status_flags), 32'h2);
    @(posedge clk); #1;
    chk("flush_never_seen", 32'(out_valid), 32'd0);
    // rd=0 never forwards
    issue(4'b0000, 32'h0000_0044, 5'd0, 4'b0000, 1'b0, 1'b0);
    chk("rd0_out_valid", 32'(out_valid), 32'd1);
    chk("rd0_fwd_valid", 32'(fwd_valid), 32'd0);
    // Retire during flush still counts
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    chk("flush_retire_cnt", 32'(retired_count), 32'(ret_model[15:0]));
    chk("flush_retire_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a stall, together with flush
    out_ready = 1'b0;
    issue(4'b0001, 32'h0000_0055, 5'd10, 4'b1000, 1'b1, 1'b0);
    issue(4'b0001, 32'h0000_0066, 5'd11, 4'b0001, 1'b1, 1'b0);
    rst_n = 1'b0; flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete(); st_model = 4'h0; ret_model = 0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_status", 32'(status_flags), 32'd0);
    chk("mrst_retired", 32'(retired_count), 32'd0);
    chk("mrst_fwd_valid", 32'(fwd_valid), 32'd0);
    rst_n = 1'b1; flush = 1'b0;
    @(posedge clk); #1;

    // Counter wrap: 65535 retires, then one more
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      issue(4'b0000, 32'(i), 5'd1, 4'b0000, 1'b0, 1'b0);
    end
    drain();
    chk("cnt_ffff", 32'(retired_count), 32'h0000_FFFF);
    chk("cnt_model", 32'(retired_count), 32'(ret_model[15:0]));
    issue(4'b0101, 32'h8000_0000, 5'd31, 4'b1000, 1'b0, 1'b0);
    drain();
    chk("cnt_wrap", 32'(retired_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
